// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the fetch-stage hart scheduler.
package fetch_pkg;
    localparam int NUM_HARTS = 4;
    localparam int HART_W = $clog2(NUM_HARTS);
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;
    localparam int INST_BYTES = 4;
    typedef enum logic {READY = 1'b0, WAIT = 1'b1} hart_state_t;
endpackage

// File: rtl/hart_rr_arbiter.sv
// hart_rr_arbiter: combinational round-robin pick of the first requester after i_ptr.
module hart_rr_arbiter #(
    parameter int NUM_HARTS = fetch_pkg::NUM_HARTS,
    parameter int HART_W = fetch_pkg::HART_W
) (
    input  logic [NUM_HARTS-1:0] i_req,
    input  logic [HART_W-1:0]    i_ptr,
    output logic [NUM_HARTS-1:0] o_grant,
    output logic [HART_W-1:0]    o_idx,
    output logic                 o_any
);
    // Scan from farthest to nearest so the nearest requester after i_ptr wins; i_ptr itself is last.
    always_comb begin
        o_idx = i_ptr;
        o_any = 1'b0;
        for (int i = NUM_HARTS; i >= 1; i--) begin
            if (i_req[i_ptr + HART_W'(i)]) begin
                o_idx = i_ptr + HART_W'(i);
                o_any = 1'b1;
            end
        end
        o_grant = o_any ? (NUM_HARTS'(1) << o_idx) : '0;
    end
endmodule

// File: rtl/hart_fetch_scheduler.sv
// hart_fetch_scheduler: per-hart PC file with round-robin fetch issue into the instruction cache,
// parking harts on a miss until their refill completes and applying branch redirects.
module hart_fetch_scheduler #(
    parameter int NUM_HARTS = fetch_pkg::NUM_HARTS,
    parameter int HART_W = fetch_pkg::HART_W,
    parameter int XLEN = fetch_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = fetch_pkg::RESET_PC
) (
    input  logic                 clk,
    input  logic                 nReset,
    input  logic                 Enable,
    input  logic                 initialising,
    input  logic                 InstMiss,
    input  logic [HART_W-1:0]    FetchingmhartID,
    input  logic                 DoneRetrieving,
    input  logic [HART_W-1:0]    RetrievingDoneFor,
    input  logic                 redirect_valid,
    input  logic [HART_W-1:0]    redirect_hart,
    input  logic [XLEN-1:0]      redirect_pc,
    output logic [XLEN-1:0]      Address,
    output logic [HART_W-1:0]    mhartID_ID,
    output logic                 fetch_valid,
    output logic                 squash_IF,
    output logic [NUM_HARTS-1:0] hart_waiting
);
    import fetch_pkg::*;

    hart_state_t          r_state [NUM_HARTS];
    logic [XLEN-1:0]      r_pc [NUM_HARTS];
    logic [HART_W-1:0]    r_rr_ptr;
    logic [XLEN-1:0]      r_addr;
    logic [HART_W-1:0]    r_hart;
    logic                 r_valid;
    logic                 r_squash;
    logic [NUM_HARTS-1:0] w_req;
    logic [NUM_HARTS-1:0] w_grant;
    logic [HART_W-1:0]    w_idx;
    logic                 w_any;
    logic                 w_miss_ok;
    logic                 w_issue;
    logic [XLEN-1:0]      w_redir_pc;

    // A miss only counts when it names the hart whose fetch is actually in the cache stage.
    assign w_miss_ok = InstMiss && r_valid && FetchingmhartID == r_hart;
    assign w_issue = Enable && !initialising && w_any;
    assign w_redir_pc = redirect_pc & ~XLEN'(3);

    for (genvar h = 0; h < NUM_HARTS; h++) begin : g_hart
        logic w_redir;
        logic w_miss;
        logic w_done;
        assign w_redir = redirect_valid && redirect_hart == HART_W'(h);
        assign w_miss = w_miss_ok && FetchingmhartID == HART_W'(h);
        assign w_done = DoneRetrieving && RetrievingDoneFor == HART_W'(h);
        assign w_req[h] = r_state[h] == READY && !(r_valid && r_hart == HART_W'(h))
                          && !(InstMiss && FetchingmhartID == HART_W'(h));
        assign hart_waiting[h] = r_state[h] == WAIT;

        always_ff @(posedge clk or negedge nReset) begin
            if (!nReset) begin
                r_pc[h] <= RESET_PC;
                r_state[h] <= READY;
            end else begin
                if (w_redir)
                    r_pc[h] <= w_redir_pc;
                else if (w_miss)
                    r_pc[h] <= r_pc[h] - XLEN'(INST_BYTES);
                else if (w_issue && w_grant[h])
                    r_pc[h] <= r_pc[h] + XLEN'(INST_BYTES);
                r_state[h] <= w_done ? READY : w_miss ? WAIT : r_state[h];
            end
        end
    end

    hart_rr_arbiter #(.NUM_HARTS(NUM_HARTS), .HART_W(HART_W)) u_arb (
        .i_req  (w_req),
        .i_ptr  (r_rr_ptr),
        .o_grant(w_grant),
        .o_idx  (w_idx),
        .o_any  (w_any)
    );

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_rr_ptr <= HART_W'(NUM_HARTS - 1);
            r_addr <= '0;
            r_hart <= '0;
            r_valid <= 1'b0;
            r_squash <= 1'b0;
        end else if (Enable) begin
            r_valid <= w_issue;
            r_squash <= redirect_valid && r_valid && redirect_hart == r_hart;
            if (w_issue) begin
                r_addr <= r_pc[w_idx];
                r_hart <= w_idx;
                r_rr_ptr <= w_idx;
            end
        end
    end

    assign Address = r_addr;
    assign mhartID_ID = r_hart;
    assign fetch_valid = r_valid;
    assign squash_IF = r_squash;

    a_miss_in_flight: assert property (@(posedge clk) disable iff (!nReset)
        InstMiss |-> (r_valid && FetchingmhartID == r_hart));
endmodule

// File: tb/tb_hart_fetch_scheduler.sv
// tb_hart_fetch_scheduler: table-driven vectors with hand-derived expectations, checked through a scoreboard queue.
module tb_hart_fetch_scheduler;
    logic        clk;
    logic        nReset;
    logic        Enable;
    logic        initialising;
    logic        InstMiss;
    logic [1:0]  FetchingmhartID;
    logic        DoneRetrieving;
    logic [1:0]  RetrievingDoneFor;
    logic        redirect_valid;
    logic [1:0]  redirect_hart;
    logic [31:0] redirect_pc;
    logic [31:0] Address;
    logic [1:0]  mhartID_ID;
    logic        fetch_valid;
    logic        squash_IF;
    logic [3:0]  hart_waiting;

    typedef struct packed {
        logic        v;
        logic [1:0]  h;
        logic [31:0] a;
        logic        s;
        logic [3:0]  w;
    } exp_t;

    typedef struct {
        logic        en, init, miss;
        logic [1:0]  mh;
        logic        done;
        logic [1:0]  dh;
        logic        rv;
        logic [1:0]  rh;
        logic [31:0] rpc;
        exp_t        e;
    } vec_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   n_pre;

    hart_fetch_scheduler dut (
        .clk              (clk),
        .nReset           (nReset),
        .Enable           (Enable),
        .initialising     (initialising),
        .InstMiss         (InstMiss),
        .FetchingmhartID  (FetchingmhartID),
        .DoneRetrieving   (DoneRetrieving),
        .RetrievingDoneFor(RetrievingDoneFor),
        .redirect_valid   (redirect_valid),
        .redirect_hart    (redirect_hart),
        .redirect_pc      (redirect_pc),
        .Address          (Address),
        .mhartID_ID       (mhartID_ID),
        .fetch_valid      (fetch_valid),
        .squash_IF        (squash_IF),
        .hart_waiting     (hart_waiting)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no end, required end of test");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(logic en, logic init, logic miss, logic [1:0] mh, logic done, logic [1:0] dh,
                                logic rv, logic [1:0] rh, logic [31:0] rpc,
                                logic v, logic [1:0] h, logic [31:0] a, logic s, logic [3:0] w);
        vec_t t;
        t.en = en; t.init = init; t.miss = miss; t.mh = mh; t.done = done; t.dh = dh;
        t.rv = rv; t.rh = rh; t.rpc = rpc;
        t.e = '{v: v, h: h, a: a, s: s, w: w};
        return t;
    endfunction

    task automatic check(input string name, input exp_t got, input exp_t exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got valid=%0b hart=%0d addr=%h squash=%0b wait=%b, required valid=%0b hart=%0d addr=%h squash=%0b wait=%b",
                     name, got.v, got.h, got.a, got.s, got.w, exp.v, exp.h, exp.a, exp.s, exp.w);
        end
    endtask

    function automatic exp_t sample();
        return '{v: fetch_valid, h: mhartID_ID, a: Address, s: squash_IF, w: hart_waiting};
    endfunction

    task automatic drive(input vec_t t);
        Enable = t.en; initialising = t.init;
        InstMiss = t.miss; FetchingmhartID = t.mh;
        DoneRetrieving = t.done; RetrievingDoneFor = t.dh;
        redirect_valid = t.rv; redirect_hart = t.rh; redirect_pc = t.rpc;
    endtask

    task automatic run(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            drive(tbl[i]);
            sb.push_back(tbl[i].e);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), sample(), sb.pop_front());
        end
    endtask

    initial begin
        // columns: en init miss mh done dh rv rh rpc | valid hart addr squash wait
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0, 1,0,32'h0,0,4'b0000));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0, 1,1,32'h0,0,4'b0000));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0, 1,2,32'h0,0,4'b0000));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0, 1,3,32'h0,0,4'b0000));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0, 1,0,32'h4,0,4'b0000));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0, 1,1,32'h4,0,4'b0000));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0, 1,2,32'h4,0,4'b0000));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0, 1,3,32'h4,0,4'b0000));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0, 1,0,32'h8,0,4'b0000));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0, 1,1,32'h8,0,4'b0000));
        tbl.push_back(mk(1,0,1,1,0,0,0,0,0, 1,2,32'h8,0,4'b0010));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0, 1,3,32'h8,0,4'b0010));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0, 1,0,32'hC,0,4'b0010));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0, 1,2,32'hC,0,4'b0010));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0, 1,3,32'hC,0,4'b0010));
        tbl.push_back(mk(1,0,0,0,1,1,0,0,0, 1,0,32'h10,0,4'b0000));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0, 1,1,32'h8,0,4'b0000));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0, 1,2,32'h10,0,4'b0000));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0, 1,3,32'h10,0,4'b0000));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0, 1,0,32'h14,0,4'b0000));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0, 1,1,32'hC,0,4'b0000));
        tbl.push_back(mk(1,0,1,1,0,0,0,0,0, 1,2,32'h14,0,4'b0010));
        tbl.push_back(mk(1,0,1,2,0,0,0,0,0, 1,3,32'h14,0,4'b0110));
        tbl.push_back(mk(1,0,1,3,0,0,0,0,0, 1,0,32'h18,0,4'b1110));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0, 0,0,32'h18,0,4'b1110));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0, 1,0,32'h1C,0,4'b1110));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0, 0,0,32'h1C,0,4'b1110));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0, 1,0,32'h20,0,4'b1110));
        tbl.push_back(mk(1,0,0,0,1,2,0,0,0, 0,0,32'h20,0,4'b1010));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0, 1,2,32'h14,0,4'b1010));
        tbl.push_back(mk(1,0,0,0,0,0,1,2,32'h100, 1,0,32'h24,1,4'b1010));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0, 1,2,32'h100,0,4'b1010));
        tbl.push_back(mk(1,0,0,0,1,3,0,0,0, 1,0,32'h28,0,4'b0010));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0, 1,2,32'h104,0,4'b0010));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0, 1,3,32'h14,0,4'b0010));
        tbl.push_back(mk(1,0,1,3,0,0,1,3,32'h200, 1,0,32'h2C,1,4'b1010));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0, 1,2,32'h108,0,4'b1010));
        tbl.push_back(mk(1,0,0,0,1,3,0,0,0, 1,0,32'h30,0,4'b0010));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0, 1,2,32'h10C,0,4'b0010));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0, 1,3,32'h200,0,4'b0010));
        tbl.push_back(mk(1,1,0,0,0,0,0,0,0, 0,3,32'h200,0,4'b0010));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 0,3,32'h200,0,4'b0010));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0, 1,0,32'h34,0,4'b0010));
        tbl.push_back(mk(0,0,1,0,0,0,0,0,0, 1,0,32'h34,0,4'b0011));
        n_pre = tbl.size();
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0, 1,0,32'h0,0,4'b0000));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0, 1,1,32'h0,0,4'b0000));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0, 1,2,32'h0,0,4'b0000));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0, 1,3,32'h0,0,4'b0000));
        tbl.push_back(mk(1,0,0,0,0,0,1,1,32'hFFFF_FFFF, 1,0,32'h4,0,4'b0000));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0, 1,1,32'hFFFF_FFFC,0,4'b0000));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0, 1,2,32'h4,0,4'b0000));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0, 1,3,32'h4,0,4'b0000));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0, 1,0,32'h8,0,4'b0000));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0, 1,1,32'h0,0,4'b0000));

        nReset = 0;
        drive(mk(1,0,0,0,0,0,0,0,0, 0,0,0,0,0));
        #1;
        check("reset_state", sample(), '0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset_held", sample(), '0);
        nReset = 1;
        run(0, n_pre);

        #3;
        nReset = 0;
        #1;
        check("async_reset_mid_wait", sample(), '0);
        @(posedge clk);
        #1;
        check("async_reset_hold", sample(), '0);
        nReset = 1;
        run(n_pre, tbl.size());

        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries left, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
